// File: rtl/despejo_registradores.sv
// Sequential dumper for the register bank: streams R0..R(NUM_REGS-1) over valid/ready.
// Define DESPEJO_CHECKSUM_EN to append a mod-2^LARGURA checksum beat after the last register.
module despejo_registradores #(
  parameter int NUM_REGS    = 8,
  parameter int LARGURA     = 8,
  parameter int LARGURA_END = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Iniciar,
  output logic [LARGURA_END-1:0] RegLido,
  input  logic [LARGURA-1:0]     DadoLido,
  output logic [LARGURA-1:0]     DadoSaida,
  output logic [LARGURA_END-1:0] NumReg,
  output logic                   Valido,
  input  logic                   Pronto,
  output logic                   Ocupado,
  output logic                   Concluido,
  output logic                   EhChecksum
);

  localparam logic [LARGURA_END-1:0] ULTIMO = LARGURA_END'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    LER,
    ENVIAR,
`ifdef DESPEJO_CHECKSUM_EN
    SOMA,
`endif
    FIM
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [LARGURA_END-1:0] idx_q, idx_d;
  logic [LARGURA-1:0]     dado_q, dado_d;
  logic [LARGURA_END-1:0] num_q, num_d;
  logic                   valido_q, valido_d;
  logic                   ocupado_q, ocupado_d;
  logic                   aceito;

`ifdef DESPEJO_CHECKSUM_EN
  logic [LARGURA-1:0]     soma_q, soma_d;
  logic                   chk_q, chk_d;
`endif

  assign aceito = valido_q & Pronto;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_q  <= OCIOSO;
      idx_q     <= '0;
      dado_q    <= '0;
      num_q     <= '0;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
`ifdef DESPEJO_CHECKSUM_EN
      soma_q    <= '0;
      chk_q     <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      dado_q    <= dado_d;
      num_q     <= num_d;
      valido_q  <= valido_d;
      ocupado_q <= ocupado_d;
`ifdef DESPEJO_CHECKSUM_EN
      soma_q    <= soma_d;
      chk_q     <= chk_d;
`endif
    end
  end

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    dado_d    = dado_q;
    num_d     = num_q;
    valido_d  = valido_q;
    ocupado_d = ocupado_q;
`ifdef DESPEJO_CHECKSUM_EN
    soma_d    = soma_q;
    chk_d     = chk_q;
`endif
    unique case (estado_q)
      OCIOSO: begin
        if (Iniciar) begin
          idx_d     = '0;
          ocupado_d = 1'b1;
`ifdef DESPEJO_CHECKSUM_EN
          soma_d    = '0;
`endif
          estado_d  = LER;
        end
      end
      LER: begin
        dado_d   = DadoLido;
        num_d    = idx_q;
        valido_d = 1'b1;
`ifdef DESPEJO_CHECKSUM_EN
        soma_d   = soma_q + DadoLido;
`endif
        estado_d = ENVIAR;
      end
      ENVIAR: begin
        if (aceito) begin
          valido_d = 1'b0;
          if (idx_q == ULTIMO) begin
`ifdef DESPEJO_CHECKSUM_EN
            // Checksum beat is presented right away; SOMA is its send phase.
            dado_d   = soma_q;
            num_d    = '0;
            chk_d    = 1'b1;
            valido_d = 1'b1;
            estado_d = SOMA;
`else
            ocupado_d = 1'b0;
            estado_d  = FIM;
`endif
          end else begin
            idx_d    = idx_q + 1'b1;
            estado_d = LER;
          end
        end
      end
`ifdef DESPEJO_CHECKSUM_EN
      SOMA: begin
        if (aceito) begin
          valido_d  = 1'b0;
          chk_d     = 1'b0;
          ocupado_d = 1'b0;
          estado_d  = FIM;
        end
      end
`endif
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign RegLido   = idx_q;
  assign DadoSaida = dado_q;
  assign NumReg    = num_q;
  assign Valido    = valido_q;
  assign Ocupado   = ocupado_q;
  assign Concluido = (estado_q == FIM);

`ifdef DESPEJO_CHECKSUM_EN
  assign EhChecksum = chk_q;
`else
  assign EhChecksum = 1'b0;
`endif

endmodule

// File: tb/tb_despejo_registradores.sv
// Bench for despejo_registradores: random bank contents and ready stalls
// checked against a beat-queue model of the dump.
module tb_despejo_registradores;

  localparam int N = 8;
  localparam int W = 8;
  localparam int A = 3;
`ifdef DESPEJO_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Iniciar;
  logic         Pronto;
  logic [A-1:0] RegLido;
  logic [A-1:0] NumReg;
  logic [W-1:0] DadoLido;
  logic [W-1:0] DadoSaida;
  logic         Valido;
  logic         Ocupado;
  logic         Concluido;
  logic         EhChecksum;

  logic [W-1:0] bank [N];

  int n_vec = 0;
  int n_err = 0;

  assign DadoLido = bank[RegLido];

  always #5 Clock = ~Clock;

  despejo_registradores #(
    .NUM_REGS(N), .LARGURA(W), .LARGURA_END(A)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Iniciar(Iniciar),
    .RegLido(RegLido),
    .DadoLido(DadoLido),
    .DadoSaida(DadoSaida),
    .NumReg(NumReg),
    .Valido(Valido),
    .Pronto(Pronto),
    .Ocupado(Ocupado),
    .Concluido(Concluido),
    .EhChecksum(EhChecksum)
  );

  task automatic verifica(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic carrega_padrao();
    for (int i = 0; i < N; i++) bank[i] = W'(8'h10 + 8'h11 * i);
  endtask

  // Full dump with ready tied high: fixed beat cadence and pulse timing.
  task automatic temporizacao();
    bit ev;
    Pronto = 1'b1;
    @(negedge Clock);
    Iniciar = 1'b1;
    for (int c = 1; c <= 2 * N + CHK + 2; c++) begin
      @(negedge Clock);
      Iniciar = 1'b0;
      ev = ((c % 2 == 0) && c <= 2 * N) || (CHK == 1 && c == 2 * N + 1);
      verifica("tim_valido", Valido, ev);
      verifica("tim_concluido", Concluido, c == 2 * N + CHK + 1);
      if (c <= 2 * N) verifica("tim_ocupado_alto", Ocupado, 1);
      if (c > 2 * N + CHK + 1) verifica("tim_ocupado_baixo", Ocupado, 0);
      if (ev && c <= 2 * N) begin
        verifica("tim_dado", DadoSaida, bank[c/2-1]);
        verifica("tim_num", NumReg, c / 2 - 1);
        verifica("tim_chk", EhChecksum, 0);
      end
    end
  endtask

  // One dump against a queue of expected beats {EhChecksum, NumReg, DadoSaida}.
  task automatic despejo(input int pct, input int stall_reg, input bit cutuca);
    logic [A+W:0] exp_q[$];
    logic [A+W:0] obs;
    logic [A+W:0] held;
    bit           hold;
    bit           done;
    int           soma;
    int           beats;
    int           stall;
    hold  = 1'b0;
    done  = 1'b0;
    soma  = 0;
    beats = 0;
    stall = 0;
    held  = '0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({1'b0, A'(i), bank[i]});
      soma += int'(bank[i]);
    end
    if (CHK == 1) exp_q.push_back({1'b1, A'(0), W'(soma)});
    @(negedge Clock);
    Iniciar = 1'b1;
    Pronto  = 1'b0;
    for (int c = 1; c <= 600 && !done; c++) begin
      @(negedge Clock);
      Iniciar = cutuca && (c == 6 || c == 7);
      obs = {EhChecksum, NumReg, DadoSaida};
      if (hold) begin
        verifica("estavel_valido", Valido, 1);
        verifica("estavel_dado", obs, held);
      end
      if (Concluido) begin
        verifica("conc_sem_valido", Valido, 0);
        verifica("fila_vazia", exp_q.size(), 0);
        done = 1'b1;
      end
      if (Valido && !EhChecksum && int'(NumReg) == stall_reg && stall < 5) begin
        Pronto = 1'b0;
        stall++;
      end else begin
        Pronto = ($urandom_range(99) < pct);
      end
      hold = Valido && !Pronto;
      held = obs;
      if (Valido && Pronto) begin
        beats++;
        if (exp_q.size() == 0) verifica("beat_extra", beats, N + CHK);
        else verifica("beat", obs, exp_q.pop_front());
      end
    end
    verifica("timeout", done, 1);
    verifica("n_beats", beats, N + CHK);
    Pronto  = 1'b0;
    Iniciar = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      verifica("ocioso_valido", Valido, 0);
      verifica("ocioso_ocupado", Ocupado, 0);
      verifica("ocioso_concluido", Concluido, 0);
    end
  endtask

  task automatic reset_no_meio();
    bit achou;
    achou  = 1'b0;
    Pronto = 1'b1;
    @(negedge Clock);
    Iniciar = 1'b1;
    for (int c = 1; c <= 100 && !achou; c++) begin
      @(negedge Clock);
      Iniciar = 1'b0;
      if (Valido && NumReg == 3'd4) begin
        achou  = 1'b1;
        Pronto = 1'b0;
      end
    end
    verifica("rst_chegou_beat4", achou, 1);
    #2 Reset = 1'b1;
    #1;
    verifica("rst_valido", Valido, 0);
    verifica("rst_ocupado", Ocupado, 0);
    verifica("rst_dado", DadoSaida, 0);
    verifica("rst_num", NumReg, 0);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (2) begin
      @(negedge Clock);
      verifica("rst_nao_retoma", {Valido, Ocupado}, 0);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    Iniciar = 1'b0;
    Pronto  = 1'b0;
    for (int i = 0; i < N; i++) bank[i] = W'($urandom);
    repeat (2) @(negedge Clock);
    verifica("ini_valido", Valido, 0);
    verifica("ini_ocupado", Ocupado, 0);
    verifica("ini_concluido", Concluido, 0);
    verifica("ini_dado", DadoSaida, 0);
    verifica("ini_num", NumReg, 0);
    verifica("ini_reglido", RegLido, 0);
    verifica("ini_chk", EhChecksum, 0);
    Reset = 1'b0;
    @(negedge Clock);

    carrega_padrao();
    temporizacao();
    despejo(100, 3, 1'b0);
    despejo(100, -1, 1'b1);
    reset_no_meio();
    despejo(100, -1, 1'b0);

    for (int i = 0; i < N; i++) bank[i] = 8'hFF;
    despejo(70, -1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) bank[i] = W'($urandom);
      despejo(int'($urandom_range(100, 30)), int'($urandom_range(N - 1)),
              k[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
